// File: rtl/booth_pkg.sv
// ============================================================================
// Module  : booth_pkg
// Brief   : Shared state encoding and Booth decode constants for the sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package booth_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    EVAL    = 3'd2,
    SHIFT   = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } booth_state_e;

  // {Q[0], Q-1} patterns that call for an add or a subtract of M
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

`default_nettype wire

// File: rtl/booth_iter_counter.sv
// ============================================================================
// Module  : booth_iter_counter
// Brief   : Saturating Booth iteration counter with clear and terminal flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module booth_iter_counter #(
  parameter int WORD_LENGTH = 8,
  parameter int CNT_WIDTH   = $clog2(WORD_LENGTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clear,
  input  logic                 i_enable,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_terminal
);

  localparam logic [CNT_WIDTH-1:0] C_LAST = CNT_WIDTH'(WORD_LENGTH - 1);
  localparam logic [CNT_WIDTH-1:0] C_MAX  = CNT_WIDTH'(WORD_LENGTH);

  logic [CNT_WIDTH-1:0] r_count;

  // Saturates at WORD_LENGTH so the count never wraps past a full operation
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != C_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count    = r_count;
  assign o_terminal = (r_count == C_LAST);

endmodule

`default_nettype wire

// File: rtl/booth_sequencer.sv
// ============================================================================
// Module  : booth_sequencer
// Brief   : FSM issuing load/add/sub/shift/capture strobes to a radix-2 Booth
//           multiplier datapath, with a one-cycle ready pulse on completion.
// Revision: 1.0
// ============================================================================
`default_nettype none

module booth_sequencer
  import booth_pkg::*;
#(
  parameter  int WORD_LENGTH = 8,
  localparam int CNT_WIDTH   = $clog2(WORD_LENGTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           q_pair,
  output logic                 load,
  output logic                 add,
  output logic                 sub,
  output logic                 shift,
  output logic                 capture,
  output logic                 busy,
  output logic                 ready,
  output logic [CNT_WIDTH-1:0] iter_count
);

  booth_state_e r_state;
  booth_state_e w_state_next;

  logic r_load;
  logic r_shift;
  logic r_capture;
  logic r_busy;
  logic r_ready;

  logic w_cnt_clear;
  logic w_cnt_enable;
  logic w_cnt_terminal;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    w_state_next = start ? LOAD : IDLE;
      LOAD:    w_state_next = EVAL;
      EVAL:    w_state_next = SHIFT;
      SHIFT:   w_state_next = w_cnt_terminal ? CAPTURE : EVAL;
      CAPTURE: w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with r_state
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_load    <= 1'b0;
      r_shift   <= 1'b0;
      r_capture <= 1'b0;
      r_busy    <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_load    <= (w_state_next == LOAD);
      r_shift   <= (w_state_next == SHIFT);
      r_capture <= (w_state_next == CAPTURE);
      r_busy    <= (w_state_next == LOAD)  || (w_state_next == EVAL) ||
                   (w_state_next == SHIFT) || (w_state_next == CAPTURE);
      r_ready   <= (w_state_next == DONE);
    end
  end

  // Clearing on acceptance makes iter_count read 0 during the LOAD cycle
  assign w_cnt_clear  = (r_state == IDLE) && start;
  assign w_cnt_enable = (r_state == SHIFT);

  booth_iter_counter #(
    .WORD_LENGTH (WORD_LENGTH),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_iter_counter (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_cnt_clear),
    .i_enable   (w_cnt_enable),
    .o_count    (iter_count),
    .o_terminal (w_cnt_terminal)
  );

  assign add     = (r_state == EVAL) && (q_pair == BOOTH_ADD);
  assign sub     = (r_state == EVAL) && (q_pair == BOOTH_SUB);
  assign load    = r_load;
  assign shift   = r_shift;
  assign capture = r_capture;
  assign busy    = r_busy;
  assign ready   = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_booth_sequencer.sv
// ============================================================================
// Module  : tb_booth_sequencer
// Brief   : Self-checking bench for booth_sequencer using an offset-based
//           timing model and a ready-cycle scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_booth_sequencer;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    q_pair;
  logic          load, add, sub, shift, capture, busy, ready;
  logic [CW-1:0] iter_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  bit m_active = 1'b0;
  int m_t0     = 0;
  int m_cnt    = 0;
  int ready_q[$];

  always #5 clk = ~clk;

  booth_sequencer #(
    .WORD_LENGTH (N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .q_pair     (q_pair),
    .load       (load),
    .add        (add),
    .sub        (sub),
    .shift      (shift),
    .capture    (capture),
    .busy       (busy),
    .ready      (ready),
    .iter_count (iter_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected outputs from the offset d since the cycle start was accepted
  function automatic logic [31:0] model_vec(input logic [1:0] q);
    logic [31:0] v;
    logic ld, ad, sb, sh, cp, bz, rd, ev;
    int d, cnt;
    v = '0;
    {ld, ad, sb, sh, cp, bz, rd, ev} = '0;
    cnt = m_cnt;
    if (m_active) begin
      d   = cyc - m_t0;
      ld  = (d == 1);
      ev  = (d >= 2) && (d <= 2 * N) && (d % 2 == 0);
      ad  = ev && (q == 2'b01);
      sb  = ev && (q == 2'b10);
      sh  = (d >= 3) && (d <= 2 * N + 1) && (d % 2 == 1);
      cp  = (d == 2 * N + 2);
      rd  = (d == 2 * N + 3);
      bz  = (d >= 1) && (d <= 2 * N + 2);
      cnt = (d >= 2) ? (d - 2) / 2 : 0;
    end
    v[CW-1:0] = CW'(cnt);
    v[CW+:7]  = {ld, ad, sb, sh, cp, bz, rd};
    return v;
  endfunction

  task automatic tick(input logic s, input logic r, input logic [1:0] q);
    logic [31:0] got;
    int          exp_rdy;
    bit          idle_now;
    int          d;
    start  = s;
    reset  = r;
    q_pair = q;
    #2;
    if (chk_en) begin
      got = '0;
      got[CW-1:0] = iter_count;
      got[CW+:7]  = {load, add, sub, shift, capture, busy, ready};
      check_eq("outputs", got, model_vec(q));
      if (add === 1'b1 && sub === 1'b1) check_eq("add_sub_excl", 32'd1, 32'd0);
      if (ready === 1'b1) begin
        if (ready_q.size() == 0) begin
          check_eq("ready_unexpected", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          exp_rdy = ready_q.pop_front();
          check_eq("ready_cycle", 32'(cyc), 32'(exp_rdy));
        end
      end
    end
    idle_now = !m_active;
    d        = cyc - m_t0;
    if (!r) begin
      m_active = 1'b0;
      m_cnt    = 0;
      ready_q.delete();
    end else begin
      if (m_active && d == 2 * N + 3) begin
        m_active = 1'b0;
        m_cnt    = N;
      end
      if (idle_now && s) begin
        m_active = 1'b1;
        m_t0     = cyc;
        ready_q.push_back(cyc + 2 * N + 3);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [1:0] rq();
    return 2'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [1:0] q;
    reset  = 1'b0;
    start  = 1'b1;
    q_pair = 2'b00;

    // Reset held with start high, then released with start low
    tick(1'b1, 1'b0, 2'b01);
    chk_en = 1'b1;
    tick(1'b1, 1'b0, 2'b01);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, rq());

    // Single operation, q_pair = 00
    tick(1'b1, 1'b1, 2'b00);
    for (int i = 0; i < 22; i++) tick(1'b0, 1'b1, 2'b00);

    // Booth decode in the first four EVAL cycles; 01 elsewhere
    for (int i = 0; i < 23; i++) begin
      case (i)
        2:       q = 2'b01;
        4:       q = 2'b10;
        6:       q = 2'b00;
        8:       q = 2'b11;
        default: q = 2'b01;
      endcase
      tick(i == 0, 1'b1, q);
    end

    // Back-to-back with start held
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b1, rq());
    for (int i = 0; i < 24; i++) tick(1'b0, 1'b1, rq());

    // start mid-op and in DONE is ignored
    for (int i = 0; i < 26; i++) tick((i == 0) || (i == 7) || (i == 19), 1'b1, rq());

    // Reset mid-op, then a fresh op
    for (int i = 0; i < 36; i++) tick((i == 0) || (i == 12), i != 10, rq());

    check_eq("ready_pending", 32'(ready_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/booth_sequencer.md
Name: booth_sequencer

Overview:
- FSM controller that sequences a radix-2 Booth shift-add multiplier datapath (A/Q/Q-1/M registers, adder/subtractor, result register).
- Accepts a start request and issues per-cycle load, add, sub, shift and capture strobes for WORD_LENGTH iterations.
- Signals completion with a one-cycle ready pulse.
- Sits between the requesting logic and the multiplier datapath; the datapath no longer free-runs.

Parameters:
- WORD_LENGTH, 8, operand width; also the number of Booth iterations N.
- CNT_WIDTH (localparam), $clog2(WORD_LENGTH+1), iteration counter width (4 for default).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request a new multiplication; sampled only in IDLE.
- q_pair  input  2  {Q[0], Q-1} from the datapath; Booth decode input.
- load  output  1  load M and Q from operands, clear A and Q-1.
- add  output  1  A <= A + M this cycle.
- sub  output  1  A <= A - M this cycle.
- shift  output  1  arithmetic right shift of {A,Q,Q-1}.
- capture  output  1  enable for the result register.
- busy  output  1  operation in progress.
- ready  output  1  one-cycle pulse: result register valid.
- iter_count  output  CNT_WIDTH  completed iterations.

Behaviour:
- Reset: reset=0 at a rising edge → state IDLE, iter_count=0. All strobes, busy and ready are 0 in the following cycle. Reset overrides start and any in-flight operation; no ready is issued for an aborted op.
- States: IDLE, LOAD, EVAL, SHIFT, CAPTURE, DONE.
- IDLE: all outputs 0. start=1 → LOAD, else stay.
- LOAD (1 cycle): load=1, busy=1, iter_count cleared to 0 → EVAL.
- EVAL (1 cycle): busy=1. add/sub are a combinational decode of q_pair, valid in EVAL only:
  - 2'b01 → add=1
  - 2'b10 → sub=1
  - 2'b00 or 2'b11 → neither
  - add and sub are never both 1.
  - Next state SHIFT.
- SHIFT (1 cycle): shift=1, busy=1, iter_count increments.
  - If iter_count (pre-increment) == WORD_LENGTH-1 → CAPTURE.
  - Else → EVAL.
- CAPTURE (1 cycle): capture=1, busy=1 → DONE.
- DONE (1 cycle): ready=1, busy=0; iter_count holds WORD_LENGTH → IDLE.
- Output types: load/shift/capture/busy/ready are Moore decodes of the registered state. add/sub are Mealy on q_pair in EVAL.
- start handling:
  - Ignored in LOAD..DONE; there is no queuing.
  - If start is high in DONE, it is not accepted; it must still be high in the following IDLE cycle.
  - start held high → back-to-back ops with period 2N+4 cycles.
- Latency (start sampled in IDLE at cycle 0):
  - LOAD at cycle 1.
  - EVAL at cycles 2,4,…,2N; SHIFT at cycles 3,5,…,2N+1.
  - CAPTURE at 2N+2, ready at 2N+3 (19 for N=8).
- iter_count: holds its value in IDLE until the next LOAD clears it. Never exceeds WORD_LENGTH; no wrap.
- Strobe exclusivity: at most one of load/add/sub/shift/capture is 1 in any cycle.

Decomposition:
- booth_pkg holds:
  - state enum typedef (booth_state_e: IDLE, LOAD, EVAL, SHIFT, CAPTURE, DONE)
  - Booth decode constants (BOOTH_ADD=2'b01, BOOTH_SUB=2'b10)
- One sub-module, booth_iter_counter: parameterized CNT_WIDTH counter with sync active-low reset, clear, enable, and terminal flag (count == WORD_LENGTH-1).

Test Plan:
- Reset: reset=0 for 2 cycles with start=1 → load/add/sub/shift/capture/busy/ready all 0, iter_count=0; no LOAD after release unless start is still 1.
- Single op, N=8: start pulse at cycle 0, q_pair=00 →
  - load at cycle 1 only
  - shift at cycles 3,5,…,17 (8 pulses)
  - capture at cycle 18, ready at cycle 19 only
  - busy high cycles 1–18; iter_count=8 at cycle 19
  - add/sub never asserted.
- Booth decode: q_pair = 01, 10, 00, 11 in the first four EVAL cycles → add, sub, none, none respectively; add&sub never both 1; no add/sub outside EVAL even with q_pair=01.
- Back-to-back: start held high → LOAD at cycles 1 and 21; ready at cycles 19 and 39; exactly 8 shifts per op.
- start asserted at cycle 7 (mid-op) and cycle 19 (DONE) only → ignored; single LOAD; state IDLE at cycle 20 with no further activity.
- Reset mid-op: reset=0 at cycle 10 → cycle 11 all outputs 0, state IDLE, no ready. start at cycle 12 → normal op with ready at cycle 31.
